// File: rtl/mult_seq_32.sv
// mult_seq_32: sequential shift-add multiplier, signed or unsigned operands.
// Fixed latency of DATA_WIDTH+2 cycles from accepted START to the DONE pulse.
// Negative signed operands become magnitudes first; the sign is applied to the final product.
module mult_seq_32 #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  SIGNED,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    FIN  = 2'd3
  } stateE;

  stateE         state;

  // Operands captured with START
  logic [W-1:0]  aReg;
  logic [W-1:0]  bReg;
  logic          signedReg;

  // Datapath registers
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic [W-1:0]  acc;
  logic          resultNeg;
  logic [CW-1:0] iterCnt;

  // Combinational datapath
  logic [W-1:0]  magA;
  logic [W-1:0]  magB;
  logic [W-1:0]  addend;
  logic [W:0]    sum;
  logic [PW-1:0] product;
  logic [PW-1:0] productFix;

  // Operand magnitudes; the most negative value maps onto itself as an unsigned magnitude
  always_comb begin
    magA = aReg;
    magB = bReg;
    if (signedReg && aReg[W-1]) begin
      magA = ~aReg + W'(1);
    end
    if (signedReg && bReg[W-1]) begin
      magB = ~bReg + W'(1);
    end
  end

  // One shift-add step: add multiplicand when multiplier LSB is set, keep the carry-out
  always_comb begin
    addend = mplier[0] ? mcand : '0;
    sum    = {1'b0, acc} + {1'b0, addend};
  end

  // Final product with sign correction; negating zero yields zero
  always_comb begin
    product    = {acc, mplier};
    productFix = product;
    if (resultNeg) begin
      productFix = ~product + PW'(1);
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      aReg      <= '0;
      bReg      <= '0;
      signedReg <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      resultNeg <= 1'b0;
      iterCnt   <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            aReg      <= A;
            bReg      <= B;
            signedReg <= SIGNED;
            BUSY      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          mcand     <= magA;
          mplier    <= magB;
          acc       <= '0;
          resultNeg <= signedReg & (aReg[W-1] ^ bReg[W-1]);
          iterCnt   <= '0;
          state     <= ITER;
        end
        ITER: begin
          // {carry, acc, mplier} >> 1 as one wide value
          acc     <= sum[W:1];
          mplier  <= {sum[0], mplier[W-1:1]};
          iterCnt <= iterCnt + CW'(1);
          if (iterCnt == CW'(W - 1)) begin
            state <= FIN;
          end
        end
        FIN: begin
          HI    <= productFix[PW-1:W];
          LO    <= productFix[W-1:0];
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_32.sv
// tb_mult_seq_32: scoreboard bench for the sequential 32x32 multiplier.
module tb_mult_seq_32;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        SIGNED;
  logic [31:0] A;
  logic [31:0] B;
  logic        BUSY;
  logic        DONE;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int e0    = 0;
  logic [63:0] expQ[$];

  mult_seq_32 #(.DATA_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SIGNED(SIGNED),
    .A(A), .B(B), .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  // Count rising edges so latency can be measured
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference product computed from the operands
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sp;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      sp = sa * sb;
      return sp;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Present one START with operands and push the expected product
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [63:0] ex);
    @(negedge CLK);
    START = 1'b1; A = a; B = b; SIGNED = s;
    expQ.push_back(ex);
    e0 = cyc + 1;
    @(negedge CLK);
    START = 1'b0;
    total++;
    if (BUSY !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start got=%b want=1", BUSY);
    end
  endtask

  // Wait for DONE, check latency and result, then the one-cycle pulse and hold
  task automatic waitDone(input string name);
    int n = 0;
    logic [63:0] ex;
    logic [63:0] got;
    while (DONE !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (DONE !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout got DONE=%b want=1 within 40 cycles", name, DONE);
      if (expQ.size() > 0) void'(expQ.pop_front());
      return;
    end
    total++;
    if (cyc - e0 != 34) begin
      bad++;
      $display("FAIL %s_latency got=%0d want=34", name, cyc - e0);
    end
    ex  = (expQ.size() > 0) ? expQ.pop_front() : 64'hxxxx_xxxx_xxxx_xxxx;
    got = {HI, LO};
    total++;
    if (got !== ex) begin
      bad++;
      $display("FAIL %s_result got=%h want=%h", name, got, ex);
    end
    total++;
    if (BUSY !== 1'b0) begin
      bad++;
      $display("FAIL %s_busy_at_done got=%b want=0", name, BUSY);
    end
    @(negedge CLK);
    total++;
    if (DONE !== 1'b0 || {HI, LO} !== ex) begin
      bad++;
      $display("FAIL %s_pulse_hold got DONE=%b HILO=%h want DONE=0 HILO=%h", name, DONE, {HI, LO}, ex);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; SIGNED = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge CLK);
    total++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got BUSY=%b DONE=%b want 0 0", BUSY, DONE);
    end
    total++;
    if (HI !== 32'd0 || LO !== 32'd0) begin
      bad++;
      $display("FAIL reset_data got HI=%h LO=%h want 0 0", HI, LO);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_unsigned();
    launch(32'd7, 32'd3, 1'b0, 64'h0000_0000_0000_0015);
    waitDone("u_basic");
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    waitDone("u_max");
    launch(32'h8000_0001, 32'd3, 1'b0, 64'h0000_0001_8000_0003);
    waitDone("u_bit31");
    launch(32'd0, 32'hDEAD_BEEF, 1'b0, 64'd0);
    waitDone("u_zero_a");
    launch(32'h1234_5678, 32'd0, 1'b0, 64'd0);
    waitDone("u_zero_b");
  endtask

  task automatic test_signed();
    launch(32'hFFFF_FFFB, 32'd0, 1'b1, 64'd0);
    waitDone("s_neg_zero");
    launch(32'hFFFF_FFFE, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2);
    waitDone("s_mixed");
    launch(32'hFFFF_FFFE, 32'hFFFF_FFF9, 1'b1, 64'h0000_0000_0000_000E);
    waitDone("s_both_neg");
    launch(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    waitDone("s_min_sq");
    launch(32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000);
    waitDone("s_min_one");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      launch(a, b, s, model(a, b, s));
      waitDone("rand");
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    launch(32'd7, 32'd3, 1'b0, 64'd21);
    repeat (9) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    void'(expQ.pop_back());
    total++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset got BUSY=%b DONE=%b HI=%h LO=%h want all 0", BUSY, DONE, HI, LO);
    end
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) seen++;
    end
    total++;
    if (seen != 0 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_no_done got pulses=%0d BUSY=%b want 0 0", seen, BUSY);
    end
    launch(32'd9, 32'd11, 1'b0, 64'd99);
    waitDone("after_reset");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    logic [63:0] ex;
    launch(32'd7, 32'd3, 1'b0, 64'd21);
    // Hammer START with other operands while busy; re-arm with 5*6 in the DONE cycle
    while (DONE !== 1'b1 && n < 40) begin
      START = 1'b1; A = 32'd100; B = 32'd100; SIGNED = 1'b1;
      @(negedge CLK);
      n++;
    end
    total++;
    if (DONE !== 1'b1 || cyc - e0 != 34) begin
      bad++;
      $display("FAIL b2b_first_done got DONE=%b lat=%0d want 1 34", DONE, cyc - e0);
    end
    ex = (expQ.size() > 0) ? expQ.pop_front() : 64'hxxxx_xxxx_xxxx_xxxx;
    total++;
    if ({HI, LO} !== ex) begin
      bad++;
      $display("FAIL b2b_first_result got=%h want=%h", {HI, LO}, ex);
    end
    START = 1'b1; A = 32'd5; B = 32'd6; SIGNED = 1'b0;
    expQ.push_back(64'h0000_0000_0000_001E);
    e0 = cyc + 1;
    @(negedge CLK);
    START = 1'b0;
    total++;
    if (BUSY !== 1'b1 || DONE !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept got BUSY=%b DONE=%b want 1 0", BUSY, DONE);
    end
    waitDone("b2b_second");
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_random();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_seq_32.md
MULT_SEQ_32 -- requirements
Module: mult_seq_32

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand width; all widths below are given for the default.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 START  input  1  request to begin a multiply; sampled on each rising CLK edge.
REQ-005 SIGNED  input  1  1 = two's-complement operands, 0 = unsigned; captured with START.
REQ-006 A  input  32  multiplicand; captured with START.
REQ-007 B  input  32  multiplier; captured with START.
REQ-008 BUSY  output  1  high while a multiply is in progress.
REQ-009 DONE  output  1  one-cycle pulse marking HI/LO valid.
REQ-010 HI  output  32  upper half of the 64-bit product.
REQ-011 LO  output  32  lower half of the 64-bit product.

Function
REQ-012 The block SHALL implement the FSM states IDLE, LOAD, ITER and FIN, all registered.
REQ-013 In IDLE with START=1 at edge e0, the block SHALL capture A, B and SIGNED, go to LOAD, and raise BUSY after e0.
REQ-014 In LOAD, the block SHALL form operand magnitudes: when SIGNED=1 each negative operand is replaced by its two's-complement negation as a 32-bit unsigned value (0x80000000 stays 0x80000000); when SIGNED=0 operands pass unchanged.
REQ-015 In LOAD, the block SHALL record the result sign as A[31] XOR B[31] if SIGNED=1, else 0; clear the 32-bit accumulator and carry; load the multiplier register with the magnitude of B; clear the 6-bit iteration counter; then go to ITER.
REQ-016 Each ITER cycle SHALL: if multiplier-register bit 0 is 1, add the multiplicand magnitude to the accumulator with a 32-bit adder producing carry-out, else add 0; then shift {carry-out, accumulator, multiplier register} right by one bit as a 65-bit value; then increment the counter.
REQ-017 ITER SHALL execute exactly 32 iterations, then go to FIN.
REQ-018 In FIN, the block SHALL take the 64-bit product {accumulator, multiplier register}, negate it as a 64-bit two's-complement value if the result sign is 1, and register it into HI (bits 63:32) and LO (bits 31:0).
REQ-019 The FIN transition SHALL assert DONE for exactly one cycle, clear BUSY, and return to IDLE.
REQ-020 DONE SHALL first be high after edge e0+34 (fixed latency of 34 cycles, independent of operand values).
REQ-021 HI and LO SHALL change only on the FIN transition or on reset, and hold their value otherwise.
REQ-022 START while BUSY=1 SHALL be ignored: no recapture and no effect on the running operation.
REQ-023 START asserted during the cycle DONE is high SHALL be accepted (FSM is in IDLE), giving back-to-back operation; DONE still pulses for the completed result.
REQ-024 SIGNED=0 with operand bit 31 set SHALL be treated as a full unsigned value, with no sign correction.
REQ-025 Zero operands SHALL still take the full 34 cycles and produce HI=LO=0 (no negative zero; negating 0 yields 0).

Reset
REQ-026 Asserting RST SHALL immediately, without waiting for a CLK edge, force IDLE, BUSY=0, DONE=0, HI=0, LO=0, and clear the counter, accumulator and operand registers.
REQ-027 Reset during LOAD, ITER or FIN SHALL abort the operation with no DONE pulse and no partial result on HI/LO.
REQ-028 After RST deasserts, the first rising edge with START=1 SHALL begin a new operation normally.

Verification
REQ-029 Unsigned basic: SIGNED=0, A=7, B=3, START for 1 cycle -> DONE exactly 34 cycles later, HI=0x00000000, LO=0x00000015.
REQ-030 Unsigned max: A=0xFFFFFFFF, B=0xFFFFFFFF, SIGNED=0 -> HI=0xFFFFFFFE, LO=0x00000001 (exercises the adder carry-out path).
REQ-031 Signed mixed: SIGNED=1, A=0xFFFFFFFE (-2), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFF2 (-14); then A=-2, B=-7 -> HI=0, LO=0x0000000E.
REQ-032 Signed extreme: SIGNED=1, A=B=0x80000000 -> HI=0x40000000, LO=0x00000000; and A=0x80000000, B=1 -> HI=0xFFFFFFFF, LO=0x80000000.
REQ-033 Reset mid-operation: start 7*3, assert RST 10 cycles after START -> BUSY, DONE, HI and LO all go to 0 immediately; no DONE pulse appears afterwards.
REQ-034 Handshake: START pulses every cycle while BUSY -> only the first operation runs; START held during the DONE cycle with A=5, B=6 -> a second DONE follows 34 cycles later with LO=0x0000001E.
